// File: rtl/msq_pkg.sv
// msq_pkg: shared FSM encoding and width helpers for matrix_skew_queue
package msq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} msq_state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/msq_lane_fifo.sv
// msq_lane_fifo: single-clock lane FIFO with fall-through read data and occupancy count
module msq_lane_fifo
    import msq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end

    always_ff @(posedge CLK)
        if (push && !clear) mem[wr_ptr] <= din;
endmodule

// File: rtl/matrix_skew_queue.sv
// matrix_skew_queue: lockstep-written lane FIFOs drained with diagonal skew into a systolic array
// Optional MSQ_STALL_CNT_EN adds a saturating busy-stall cycle counter output.
module matrix_skew_queue
    import msq_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LEN_W = 8
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    flush,
    input  logic [ROWS*WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    output logic                    start_ready,
    input  logic                    stall,
    output logic [ROWS*WIDTH-1:0]   out_data,
    output logic [ROWS-1:0]         out_valid,
    output logic                    busy,
    output logic                    tile_done,
`ifdef MSQ_STALL_CNT_EN
    output logic [31:0]             stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]  level
);
    localparam int CW   = cnt_w(DEPTH);
    localparam int TW   = LEN_W + $clog2(ROWS) + 1;
    localparam int CMPW = (LEN_W > CW) ? LEN_W : CW;

    msq_state_t          state;
    logic [LEN_W-1:0]    len;
    logic [TW-1:0]       t, t_last;
    logic [ROWS-1:0]     pop, full, empty;
    logic [WIDTH-1:0]    dout [ROWS];
    logic [CW-1:0]       cnt [ROWS];
    logic [ROWS*WIDTH-1:0] pop_data;
    logic                run, push, accept;

    assign run         = state == RUN && !stall && !flush;
    assign in_ready    = &(~full | pop);
    assign push        = in_valid && in_ready && !flush;
    assign level       = cnt[0];
    assign busy        = state != IDLE;
    assign start_ready = state == IDLE && CMPW'(level) >= CMPW'(cfg_len) && cfg_len != '0 && !flush;
    assign accept      = start && start_ready;
    assign t_last      = TW'(len) + TW'(ROWS - 2);

    genvar g;
    generate
        for (g = 0; g < ROWS; g++) begin : g_lane
            // lane g drains during the window g <= t < g+L
            assign pop[g] = run && !empty[g] && t >= TW'(g) && t < TW'(g) + TW'(len);
            assign pop_data[g*WIDTH +: WIDTH] = pop[g] ? dout[g] : '0;
            msq_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
                .CLK(CLK), .RESET_N(RESET_N), .clear(flush),
                .push(push), .pop(pop[g]), .din(in_data[g*WIDTH +: WIDTH]),
                .dout(dout[g]), .full(full[g]), .empty(empty[g]), .count(cnt[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            state     <= IDLE;
            len       <= '0;
            t         <= '0;
            out_data  <= '0;
            out_valid <= '0;
            tile_done <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            len       <= '0;
            t         <= '0;
            out_data  <= '0;
            out_valid <= '0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= state == DONE;
            if (!(stall && busy)) begin
                out_valid <= pop;
                out_data  <= pop_data;
            end
            if (accept) begin
                state <= RUN;
                len   <= cfg_len;
                t     <= '0;
            end else if (state == RUN && !stall) begin
                t <= t + TW'(1);
                if (t == t_last) state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end

`ifdef MSQ_STALL_CNT_EN
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) stall_cnt <= '0;
        else if (flush || accept) stall_cnt <= '0;
        else if (busy && stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule
